// File: rtl/tx_event_arbiter_pkg.sv
// Shared types for the tx event arbiter: FSM state encoding and well-known event source IDs.
package tx_event_arbiter_pkg;

  typedef enum logic [0:0] {
    TXARB_IDLE = 1'b0,
    TXARB_REQ  = 1'b1
  } txarb_state_e;

  localparam int EVENT_ID_VBLANK  = 0;
  localparam int EVENT_ID_SPR_OVF = 1;
  localparam int EVENT_ID_PAD     = 2;
  localparam int EVENT_ID_USER    = 3;

endpackage

// File: rtl/tx_event_arbiter_if.sv
// Request/ack event channel into the synth (ext_tx_request / ext_tx_ack plus source ID).
interface tx_event_arbiter_if #(
  parameter int ID_BITS = 2
);
  logic               tx_request;
  logic [ID_BITS-1:0] tx_id;
  logic               tx_ack;

  modport master (output tx_request, output tx_id, input tx_ack);
  modport slave  (input tx_request, input tx_id, output tx_ack);
endinterface

// File: rtl/tx_event_arbiter_pick.sv
// Combinational round-robin pick: first set req bit searching upward from last+1, wrapping.
module rr_priority_pick #(
  parameter int N_SRC   = 4,
  parameter int ID_BITS = 2
) (
  input  logic [N_SRC-1:0]   req,
  input  logic [ID_BITS-1:0] last,
  output logic               valid,
  output logic [ID_BITS-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      int j;
      j = (int'(last) + k) % N_SRC;
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = ID_BITS'(j);
      end
    end
  end

endmodule

// File: rtl/tx_event_arbiter.sv
// Serialises per-source pending events onto one request/ack channel, round-robin.
// Optional saturating drop counter built only when TX_EVENT_DROP_CNT_EN is defined.
module tx_event_arbiter
  import tx_event_arbiter_pkg::*;
#(
  parameter int N_SRC    = 4,
  parameter int ID_BITS  = 2,
  parameter int CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_SRC-1:0]    src_pulse,
  input  logic [N_SRC-1:0]    src_en,
  tx_event_arbiter_if.master  tx_if,
  output logic [N_SRC-1:0]    pending,
  output logic                busy,
  output logic [CNT_BITS-1:0] drop_count
);

  txarb_state_e       state_q, state_d;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic               tx_request_q, tx_request_d;
  logic [ID_BITS-1:0] tx_id_q, tx_id_d;
  logic [ID_BITS-1:0] last_q, last_d;
  logic [N_SRC-1:0]   clr;
  logic               ack_in_req;
  logic               pick_valid;
  logic [ID_BITS-1:0] pick_idx;

  rr_priority_pick #(.N_SRC(N_SRC), .ID_BITS(ID_BITS)) u_pick (
    .req   (pending_q),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign ack_in_req = (state_q == TXARB_REQ) && tx_if.tx_ack;

  // A same-cycle pulse beats the ack clear, so that event is kept, not lost.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clr[i] = ack_in_req && (tx_id_q == ID_BITS'(i));
    end
    pending_d = src_en & (src_pulse | (pending_q & ~clr));
  end

  always_comb begin
    state_d      = state_q;
    tx_request_d = tx_request_q;
    tx_id_d      = tx_id_q;
    last_d       = last_q;
    case (state_q)
      TXARB_IDLE: begin
        if (pick_valid) begin
          tx_id_d      = pick_idx;
          tx_request_d = 1'b1;
          state_d      = TXARB_REQ;
        end
      end
      TXARB_REQ: begin
        if (tx_if.tx_ack) begin
          tx_request_d = 1'b0;
          last_d       = tx_id_q;
          state_d      = TXARB_IDLE;
        end
      end
      default: state_d = TXARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= TXARB_IDLE;
      pending_q    <= '0;
      tx_request_q <= 1'b0;
      tx_id_q      <= '0;
      last_q       <= ID_BITS'(N_SRC - 1);
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      tx_request_q <= tx_request_d;
      tx_id_q      <= tx_id_d;
      last_q       <= last_d;
    end
  end

  assign tx_if.tx_request = tx_request_q;
  assign tx_if.tx_id      = tx_id_q;
  assign pending          = pending_q;
  assign busy             = (state_q == TXARB_REQ);

`ifdef TX_EVENT_DROP_CNT_EN
  logic [N_SRC-1:0]    drop;
  logic [CNT_BITS-1:0] drop_cnt_q, drop_cnt_d;

  // Pulse on an already-pending source coalesces into the existing event.
  always_comb begin
    drop       = src_en & src_pulse & pending_q & ~clr;
    drop_cnt_d = drop_cnt_q;
    if ((|drop) && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_tx_event_arbiter.sv
// Directed bench for tx_event_arbiter; drop-count expectations follow TX_EVENT_DROP_CNT_EN.
module tb_tx_event_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] src_pulse;
  logic [3:0] src_en;
  logic [3:0] pending;
  logic       busy;
  logic [3:0] drop_count;
  int         n_chk  = 0;
  int         n_fail = 0;

  tx_event_arbiter_if #(.ID_BITS(2)) tx_if ();

  tx_event_arbiter #(.N_SRC(4), .ID_BITS(2), .CNT_BITS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_pulse  (src_pulse),
    .src_en     (src_en),
    .tx_if      (tx_if),
    .pending    (pending),
    .busy       (busy),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; src_pulse = '0; tx_if.tx_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] p);
    src_pulse = p;
    tick();
    src_pulse = '0;
  endtask

  task automatic serve(input logic [1:0] exp_id);
    int n = 0;
    while (!tx_if.tx_request && n < 10) begin tick(); n++; end
    check("req_up", tx_if.tx_request, 1);
    check("grant_id", tx_if.tx_id, exp_id);
    tick(); tick();
    check("req_hold", tx_if.tx_request, 1);
    check("id_hold", tx_if.tx_id, exp_id);
    tx_if.tx_ack = 1'b1;
    tick();
    tx_if.tx_ack = 1'b0;
    check("req_fall", tx_if.tx_request, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    src_en = 4'hF;
    do_reset();
    check("rst_req", tx_if.tx_request, 0);
    check("rst_id", tx_if.tx_id, 0);
    check("rst_pend", pending, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_count, 0);

    // 1: pulse -> pending next cycle, request the cycle after
    pulse(4'b0100);
    check("t1_pend", pending, 4'b0100);
    check("t1_req0", tx_if.tx_request, 0);
    tick();
    check("t1_req", tx_if.tx_request, 1);
    check("t1_id", tx_if.tx_id, 2);
    check("t1_busy", busy, 1);
    tx_if.tx_ack = 1'b1; tick(); tx_if.tx_ack = 1'b0;
    check("t1_clr", pending, 0);
    tick();
    check("t1_idle", tx_if.tx_request, 0);

    // 2: round robin starting after last=3
    do_reset();
    pulse(4'b1011);
    check("t2_pend", pending, 4'b1011);
    serve(0); serve(1); serve(3);
    check("t2_empty", pending, 0);
    pulse(4'b1011);
    serve(0); serve(1); serve(3);

    // 3: request survives enable drop, no re-request afterwards
    do_reset();
    pulse(4'b0010);
    tick();
    check("t3_id", tx_if.tx_id, 1);
    src_en = 4'b1101;
    tick(); tick(); tick();
    check("t3_hold", tx_if.tx_request, 1);
    check("t3_pend", pending[1], 0);
    tx_if.tx_ack = 1'b1; tick(); tx_if.tx_ack = 1'b0;
    check("t3_fall", tx_if.tx_request, 0);
    tick(); tick();
    check("t3_noreq", tx_if.tx_request, 0);
    check("t3_pend2", pending, 0);
    src_en = 4'hF;

    // 4: pulse coincident with ack keeps the event pending
    do_reset();
    pulse(4'b0001);
    tick();
    check("t4_req", tx_if.tx_request, 1);
    tx_if.tx_ack = 1'b1; src_pulse = 4'b0001;
    tick();
    tx_if.tx_ack = 1'b0; src_pulse = '0;
    check("t4_pend", pending[0], 1);
    check("t4_gap", tx_if.tx_request, 0);
    tick();
    check("t4_rereq", tx_if.tx_request, 1);
    check("t4_reid", tx_if.tx_id, 0);
    tx_if.tx_ack = 1'b1; tick(); tx_if.tx_ack = 1'b0;

    // 5: 20 pulses on a pending, unacked source
    do_reset();
    src_pulse = 4'b0001;
    repeat (5) tick();
`ifdef TX_EVENT_DROP_CNT_EN
    check("t5_drop4", drop_count, 4);
`else
    check("t5_drop4", drop_count, 0);
`endif
    repeat (15) tick();
    src_pulse = '0;
`ifdef TX_EVENT_DROP_CNT_EN
    check("t5_sat", drop_count, 15);
`else
    check("t5_sat", drop_count, 0);
`endif
    check("t5_req", tx_if.tx_request, 1);
    check("t5_id", tx_if.tx_id, 0);

    // 6: reset mid-request, then a stray ack in IDLE
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_req", tx_if.tx_request, 0);
    check("t6_pend", pending, 0);
    check("t6_busy", busy, 0);
    check("t6_drop", drop_count, 0);
    tx_if.tx_ack = 1'b1; tick(); tx_if.tx_ack = 1'b0;
    check("t6_ackign", tx_if.tx_request, 0);
    check("t6_busy2", busy, 0);
    pulse(4'b0101);
    serve(0);
    serve(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
